// File: rtl/vector_writeback.sv
// Vector writeback stage: retires ALU vectors directly and assembles serial
// per-lane load beats into one vector before issuing a single register write.

module vector_writeback_lane #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= '0;
        else if (load) q <= d;
    end

    // Forward the incoming beat so the final lane can land in wd3 on the same edge.
    assign nxt = load ? d : q;
endmodule

module vector_writeback #(
    parameter int LANES  = 3,
    parameter int WIDTH  = 18,
    parameter int REG_AW = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_m,
    output logic                         ready_m,
    input  logic                         reg_write_m,
    input  logic                         mem_to_reg_m,
    input  logic [REG_AW-1:0]            wa3m,
    input  logic [LANES-1:0][WIDTH-1:0]  alu_result_m,
    input  logic                         beat_valid,
    input  logic [WIDTH-1:0]             beat_data,
    output logic                         beat_ready,
    output logic                         RegWriteW,
    output logic [REG_AW-1:0]            wa3w,
    output logic [LANES-1:0][WIDTH-1:0]  wd3,
    output logic                         busy
);
    localparam int CW = 2;
    localparam logic [REG_AW-1:0] PC_REG = '1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q;
    logic [REG_AW-1:0]           pend_wa;
    logic                        we_q;
    logic                        accept, take, last;
    logic                        acc_alu, acc_load;
    logic [LANES-1:0][WIDTH-1:0] asm_vec;

    assign ready_m    = (state_q != COLLECT);
    assign beat_ready = (state_q == COLLECT);
    assign busy       = (state_q == COLLECT);
    assign RegWriteW  = (state_q == WRITE) && we_q;

    assign accept   = valid_m && ready_m;
    assign acc_alu  = accept && reg_write_m && !mem_to_reg_m;
    assign acc_load = accept && reg_write_m && mem_to_reg_m;
    assign take     = beat_valid && beat_ready;
    assign last     = take && (cnt_q == CW'(LANES-1));

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            vector_writeback_lane #(.WIDTH(WIDTH)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (take && (cnt_q == CW'(i))),
                .d     (beat_data),
                .nxt   (asm_vec[i])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (acc_alu)       state_d = WRITE;
                else if (acc_load) state_d = COLLECT;
            end
            COLLECT: if (last) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_wa <= '0;
            we_q    <= 1'b0;
            wa3w    <= '0;
            wd3     <= '0;
        end else begin
            state_q <= state_d;
            if (acc_load) begin
                pend_wa <= wa3m;
                cnt_q   <= '0;
            end else if (last) begin
                cnt_q   <= '0;
            end else if (take) begin
                cnt_q   <= cnt_q + 1'b1;
            end
            // The PC register still retires through WRITE but never asserts the enable.
            if (acc_alu) begin
                wa3w <= wa3m;
                wd3  <= alu_result_m;
                we_q <= (wa3m != PC_REG);
            end else if (last) begin
                wa3w <= pend_wa;
                wd3  <= asm_vec;
                we_q <= (pend_wa != PC_REG);
            end
        end
    end
endmodule

// File: tb/tb_vector_writeback.sv
// Directed bench for vector_writeback with a write scoreboard checked on every RegWriteW.

module tb_vector_writeback;
    localparam int LANES  = 3;
    localparam int WIDTH  = 18;
    localparam int REG_AW = 4;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
    typedef struct {
        logic [REG_AW-1:0] wa;
        vec_t              wd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_m = 1'b0;
    logic              ready_m;
    logic              reg_write_m = 1'b0;
    logic              mem_to_reg_m = 1'b0;
    logic [REG_AW-1:0] wa3m = '0;
    vec_t              alu_result_m = '0;
    logic              beat_valid = 1'b0;
    logic [WIDTH-1:0]  beat_data = '0;
    logic              beat_ready;
    logic              RegWriteW;
    logic [REG_AW-1:0] wa3w;
    vec_t              wd3;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    vector_writeback #(.LANES(LANES), .WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .ready_m(ready_m),
        .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .wa3m(wa3m),
        .alu_result_m(alu_result_m), .beat_valid(beat_valid), .beat_data(beat_data),
        .beat_ready(beat_ready), .RegWriteW(RegWriteW), .wa3w(wa3w), .wd3(wd3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic m2r, input logic [REG_AW-1:0] wa, input vec_t v);
        valid_m      = 1'b1;
        reg_write_m  = rw;
        mem_to_reg_m = m2r;
        wa3m         = wa;
        alu_result_m = v;
    endtask

    task automatic idle_m();
        valid_m      = 1'b0;
        reg_write_m  = 1'b0;
        mem_to_reg_m = 1'b0;
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                                input logic [WIDTH-1:0] l2);
        vec_t v;
        v[0] = l0; v[1] = l1; v[2] = l2;
        return v;
    endfunction

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && RegWriteW) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_spurious_write wa3w=%0d expected no write", wa3w);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_wa3w", 64'(wa3w), 64'(e.wa));
                chk("sb_wd3", 64'(wd3), 64'(e.wd));
            end
        end
    end

    initial begin
        vec_t v;

        // Reset state
        #2;
        chk("rst_RegWriteW", 64'(RegWriteW), 64'd0);
        chk("rst_wa3w", 64'(wa3w), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_beat_ready", 64'(beat_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready_m", 64'(ready_m), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single ALU write
        v = {18'h00001, 18'h3FFFF, 18'h12345};
        issue(1'b1, 1'b0, 4'd5, v);
        exp_q.push_back('{wa: 4'd5, wd: v});
        step();
        idle_m();
        chk("alu_we_pulse", 64'(RegWriteW), 64'd1);
        chk("alu_wd3", 64'(wd3), 64'(v));
        step();
        chk("alu_we_drop", 64'(RegWriteW), 64'd0);

        // Load with a gap after the first beat
        issue(1'b1, 1'b1, 4'd3, '0);
        exp_q.push_back('{wa: 4'd3, wd: mk(18'h0000A, 18'h0000B, 18'h0000C)});
        step();
        idle_m();
        chk("ld_ready_m", 64'(ready_m), 64'd0);
        chk("ld_busy", 64'(busy), 64'd1);
        chk("ld_beat_ready", 64'(beat_ready), 64'd1);
        chk("ld_wd3_hold", 64'(wd3), 64'(v));
        beat_valid = 1'b1; beat_data = 18'h0000A;
        step();
        beat_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("ld_gap_busy", 64'(busy), 64'd1);
            chk("ld_gap_ready_m", 64'(ready_m), 64'd0);
            chk("ld_gap_no_write", 64'(RegWriteW), 64'd0);
        end
        beat_valid = 1'b1; beat_data = 18'h0000B;
        step();
        chk("ld_partial_hidden", 64'(wd3), 64'(v));
        beat_data = 18'h0000C;
        step();
        beat_valid = 1'b0;
        chk("ld_we", 64'(RegWriteW), 64'd1);
        chk("ld_busy_done", 64'(busy), 64'd0);
        step();
        chk("ld_we_drop", 64'(RegWriteW), 64'd0);

        // Back-to-back ALU writes
        issue(1'b1, 1'b0, 4'd1, mk(18'h11, 18'h12, 18'h13));
        exp_q.push_back('{wa: 4'd1, wd: mk(18'h11, 18'h12, 18'h13)});
        step();
        chk("b2b_we0", 64'(RegWriteW), 64'd1);
        issue(1'b1, 1'b0, 4'd2, mk(18'h21, 18'h22, 18'h23));
        exp_q.push_back('{wa: 4'd2, wd: mk(18'h21, 18'h22, 18'h23)});
        step();
        chk("b2b_we1", 64'(RegWriteW), 64'd1);
        issue(1'b1, 1'b0, 4'd4, mk(18'h41, 18'h42, 18'h43));
        exp_q.push_back('{wa: 4'd4, wd: mk(18'h41, 18'h42, 18'h43)});
        step();
        idle_m();
        chk("b2b_we2", 64'(RegWriteW), 64'd1);
        chk("b2b_wa_last", 64'(wa3w), 64'd4);
        step();
        chk("b2b_we_drop", 64'(RegWriteW), 64'd0);

        // ALU write to r15 is suppressed
        issue(1'b1, 1'b0, 4'd15, mk(18'h3FFFF, 18'h3FFFF, 18'h3FFFF));
        step();
        idle_m();
        chk("r15_alu_no_we", 64'(RegWriteW), 64'd0);
        step();

        // Load to r15: beats consumed, no write
        issue(1'b1, 1'b1, 4'd15, '0);
        step();
        idle_m();
        beat_valid = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            beat_data = 18'(k + 18'h100);
            chk("r15_ld_beat_ready", 64'(beat_ready), 64'd1);
            step();
        end
        beat_valid = 1'b0;
        chk("r15_ld_no_we", 64'(RegWriteW), 64'd0);
        chk("r15_ld_ready_m", 64'(ready_m), 64'd1);
        step();
        chk("r15_ld_idle_busy", 64'(busy), 64'd0);

        // No register write: memory flag ignored, beats untouched
        issue(1'b0, 1'b1, 4'd6, '0);
        beat_valid = 1'b1; beat_data = 18'h2AAAA;
        step();
        idle_m();
        chk("nowr_beat_ready", 64'(beat_ready), 64'd0);
        chk("nowr_busy", 64'(busy), 64'd0);
        step();
        chk("nowr_no_we", 64'(RegWriteW), 64'd0);
        chk("nowr_beat_ready2", 64'(beat_ready), 64'd0);
        beat_valid = 1'b0;

        // Reset after two of three beats
        issue(1'b1, 1'b1, 4'd9, '0);
        step();
        idle_m();
        beat_valid = 1'b1; beat_data = 18'h1111;
        step();
        beat_data = 18'h2222;
        step();
        beat_valid = 1'b0;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wa3w", 64'(wa3w), 64'd0);
        chk("mid_rst_wd3", 64'(wd3), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_we", 64'(RegWriteW), 64'd0);
        chk("mid_rst_ready_m", 64'(ready_m), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready_m", 64'(ready_m), 64'd1);
        v = mk(18'h00777, 18'h00000, 18'h3F00F);
        issue(1'b1, 1'b0, 4'd7, v);
        exp_q.push_back('{wa: 4'd7, wd: v});
        step();
        idle_m();
        chk("post_rst_we", 64'(RegWriteW), 64'd1);
        chk("post_rst_wd3", 64'(wd3), 64'(v));
        step();
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
